// File: rtl/vc_buf_pkg.sv
// vc_buf_pkg: shared defaults and width derivations for the virtual-channel buffer
package vc_buf_pkg;
    localparam int DEF_WIDTH  = 256;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_NUM_VC = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int vc_w(input int n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

    function automatic int ptr_w(input int d);
        return (clog2(d) > 1) ? clog2(d) : 1;
    endfunction

    function automatic int cnt_w(input int d);
        return clog2(d + 1);
    endfunction
endpackage

// File: rtl/vc_fifo_lane.sv
// vc_fifo_lane: one FWFT circular FIFO with occupancy-derived flags
module vc_fifo_lane
    import vc_buf_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 6,
    localparam int PTR_W    = ptr_w(DEPTH),
    localparam int CNT_W    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             almost_full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // pointer wrap at DEPTH-1 so non-power-of-two depths use every slot
    always_comb begin
        head_d  = rd_en ? ((head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1)) : head_q;
        tail_d  = wr_en ? ((tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1)) : tail_q;
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end

    // pointer and occupancy state
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // storage is never cleared; reset only forgets it via the pointers
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem_q[tail_q] <= wr_data;
    end

    assign full        = count_q == CNT_W'(DEPTH);
    assign almost_full = count_q >= CNT_W'(AF_THRESH);
    assign empty       = count_q == '0;
    assign count       = count_q;
    assign rd_data     = empty ? '0 : mem_q[head_q];
endmodule

// File: rtl/vc_fifo_buffer.sv
// vc_fifo_buffer: per-VC FWFT input buffer with credit return and sticky error flags
module vc_fifo_buffer
    import vc_buf_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int NUM_VC    = DEF_NUM_VC,
    parameter int AF_THRESH = 6,
    localparam int VC_W     = vc_w(NUM_VC),
    localparam int CNT_W    = cnt_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [VC_W-1:0]         in_vc,
    input  logic                    produce,
    input  logic                    consume,
    input  logic [VC_W-1:0]         consume_vc,
    output logic [WIDTH-1:0]        out_data,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       almost_full,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC*CNT_W-1:0] count,
    output logic                    credit_valid,
    output logic [VC_W-1:0]         credit_vc,
    output logic                    overflow,
    output logic                    underflow
);
    logic [NUM_VC-1:0] in_sel, rd_sel, wr_en, rd_en;
    logic [WIDTH-1:0]  lane_data [NUM_VC];
    logic              credit_valid_q, overflow_q, underflow_q;
    logic [VC_W-1:0]   credit_vc_q;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_lane
        assign in_sel[g] = in_vc == VC_W'(g);
        assign rd_sel[g] = consume_vc == VC_W'(g);
        vc_fifo_lane #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .AF_THRESH(AF_THRESH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (wr_en[g]),
            .wr_data    (in_data),
            .rd_en      (rd_en[g]),
            .rd_data    (lane_data[g]),
            .full       (full[g]),
            .almost_full(almost_full[g]),
            .empty      (empty[g]),
            .count      (count[g*CNT_W +: CNT_W])
        );
    end

    // out-of-range VC ids decode to no lane, so the request is simply rejected
    assign wr_en = in_sel & ~full & {NUM_VC{produce}};
    assign rd_en = rd_sel & ~empty & {NUM_VC{consume}};

    // head-of-line mux; empty lanes already present zero
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_VC; k++) out_data = rd_sel[k] ? lane_data[k] : out_data;
    end

    // credit return one cycle after an accepted pop, plus sticky reject flags
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            credit_valid_q <= |rd_en;
            if (|rd_en) credit_vc_q <= consume_vc;
            overflow_q     <= overflow_q | (produce && !(|wr_en));
            underflow_q    <= underflow_q | (consume && !(|rd_en));
        end
    end

    assign credit_valid = credit_valid_q;
    assign credit_vc    = credit_vc_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
endmodule

// File: tb/tb_vc_fifo_buffer.sv
// tb_vc_fifo_buffer: directed vector table plus multi-cycle corner sequences
module tb_vc_fifo_buffer;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] in_data = '0;
    logic [1:0]   in_vc = '0;
    logic         produce = 1'b0;
    logic         consume = 1'b0;
    logic [1:0]   consume_vc = '0;
    logic [255:0] out_data;
    logic [3:0]   full, almost_full, empty;
    logic [15:0]  count;
    logic         credit_valid;
    logic [1:0]   credit_vc;
    logic         overflow, underflow;

    vc_fifo_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_vc       (in_vc),
        .produce     (produce),
        .consume     (consume),
        .consume_vc  (consume_vc),
        .out_data    (out_data),
        .full        (full),
        .almost_full (almost_full),
        .empty       (empty),
        .count       (count),
        .credit_valid(credit_valid),
        .credit_vc   (credit_vc),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       prod;
        logic [1:0] ivc;
        logic [7:0] din;
        logic       cons;
        logic [1:0] cvc;
        logic [3:0] ecnt;
        logic [7:0] eout;
        logic [3:0] efull;
        logic [3:0] eaf;
        logic [3:0] eempty;
        logic       eovf;
        logic       eunf;
        logic       ecred;
    } vec_t;

    vec_t v [64];
    int   nv = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int p, input int iv, input int din, input int c, input int cv,
                       input int ecnt, input int eout, input int efull, input int eaf,
                       input int eempty, input int eovf, input int eunf, input int ecred);
        v[nv].prod   = 1'(p);
        v[nv].ivc    = 2'(iv);
        v[nv].din    = 8'(din);
        v[nv].cons   = 1'(c);
        v[nv].cvc    = 2'(cv);
        v[nv].ecnt   = 4'(ecnt);
        v[nv].eout   = 8'(eout);
        v[nv].efull  = 4'(efull);
        v[nv].eaf    = 4'(eaf);
        v[nv].eempty = 4'(eempty);
        v[nv].eovf   = 1'(eovf);
        v[nv].eunf   = 1'(eunf);
        v[nv].ecred  = 1'(ecred);
        nv++;
    endtask

    task automatic step(input logic p, input logic [1:0] iv, input logic [255:0] d,
                        input logic c, input logic [1:0] cv);
        produce    = p;
        in_vc      = iv;
        in_data    = d;
        consume    = c;
        consume_vc = cv;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] cnt_of(input logic [1:0] vc);
        return count[int'(vc)*4 +: 4];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 2'd0, '0, 1'b0, 2'd0);
        step(1'b0, 2'd0, '0, 1'b0, 2'd0);
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_empty"}, 256'(empty), 256'(4'b1111));
        chk({tag, "_count"}, 256'(count), 256'(16'h0));
        chk({tag, "_full"}, 256'(full), 256'(4'b0000));
        chk({tag, "_af"}, 256'(almost_full), 256'(4'b0000));
        chk({tag, "_out"}, out_data, '0);
        chk({tag, "_cred"}, 256'(credit_valid), 256'(1'b0));
        chk({tag, "_credvc"}, 256'(credit_vc), 256'(2'd0));
        chk({tag, "_ovf"}, 256'(overflow), 256'(1'b0));
        chk({tag, "_unf"}, 256'(underflow), 256'(1'b0));
    endtask

    initial begin
        int pops [5] = '{1, 1, 0, 1, 0};
        int prev;
        for (int i = 1; i <= 8; i++)
            add(1, 2, i, 0, 2, i, 1, (i == 8) ? 4 : 0, (i >= 6) ? 4 : 0, 4'b1011, 0, 0, 0);
        add(1, 2, 9, 0, 2, 8, 1, 4, 4, 4'b1011, 1, 0, 0);
        for (int i = 1; i <= 8; i++)
            add(0, 2, 0, 1, 2, 8 - i, (i < 8) ? i + 1 : 0, 0, (i <= 2) ? 4 : 0,
                (i == 8) ? 4'b1111 : 4'b1011, 1, 0, 1);
        for (int i = 0; i < 5; i++)
            add(1, 0, 8'h10 + i, 0, 0, i + 1, 8'h10, 0, 0, 4'b1110, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 1, 0, 4 - i, (i < 4) ? 8'h11 + i : 0, 0, 0,
                (i == 4) ? 4'b1111 : 4'b1110, 1, 0, 1);
        for (int i = 0; i < 8; i++)
            add(1, 0, 8'hA0 + i, 0, 0, i + 1, 8'hA0, (i == 7) ? 1 : 0, (i >= 5) ? 1 : 0,
                4'b1110, 1, 0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 0, 0, 1, 0, 7 - i, (i < 7) ? 8'hA1 + i : 0, 0, (7 - i >= 6) ? 1 : 0,
                (i == 7) ? 4'b1111 : 4'b1110, 1, 0, 1);

        do_reset();
        chk_reset("rst0");

        for (int k = 0; k < nv; k++) begin
            step(v[k].prod, v[k].ivc, 256'(v[k].din), v[k].cons, v[k].cvc);
            chk($sformatf("v%0d_cnt", k), 256'(cnt_of(v[k].cvc)), 256'(v[k].ecnt));
            chk($sformatf("v%0d_out", k), out_data, 256'(v[k].eout));
            chk($sformatf("v%0d_full", k), 256'(full), 256'(v[k].efull));
            chk($sformatf("v%0d_af", k), 256'(almost_full), 256'(v[k].eaf));
            chk($sformatf("v%0d_empty", k), 256'(empty), 256'(v[k].eempty));
            chk($sformatf("v%0d_ovf", k), 256'(overflow), 256'(v[k].eovf));
            chk($sformatf("v%0d_unf", k), 256'(underflow), 256'(v[k].eunf));
            chk($sformatf("v%0d_cred", k), 256'(credit_valid), 256'(v[k].ecred));
        end

        do_reset();
        chk_reset("rst1");

        for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 256'(8'h31 + i), 1'b0, 2'd1);
        step(1'b1, 2'd1, 256'(8'h34), 1'b1, 2'd1);
        chk("vc1_rw_cnt", 256'(cnt_of(2'd1)), 256'(4'd3));
        chk("vc1_rw_out", out_data, 256'(8'h32));
        chk("vc1_rw_ovf", 256'(overflow), 256'(1'b0));
        chk("vc1_rw_unf", 256'(underflow), 256'(1'b0));
        for (int i = 0; i < 5; i++) step(1'b1, 2'd1, 256'(8'h35 + i), 1'b0, 2'd1);
        chk("vc1_full_cnt", 256'(cnt_of(2'd1)), 256'(4'd8));
        chk("vc1_full", 256'(full), 256'(4'b0010));
        step(1'b1, 2'd1, 256'(8'h3A), 1'b1, 2'd1);
        chk("vc1_fullrw_cnt", 256'(cnt_of(2'd1)), 256'(4'd7));
        chk("vc1_fullrw_out", out_data, 256'(8'h33));
        chk("vc1_fullrw_ovf", 256'(overflow), 256'(1'b1));
        chk("vc1_fullrw_full", 256'(full), 256'(4'b0000));
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 2'd1, '0, 1'b1, 2'd1);
            chk($sformatf("vc1_drain%0d_out", i), out_data, (i < 6) ? 256'(8'h34 + i) : '0);
            chk($sformatf("vc1_drain%0d_cnt", i), 256'(cnt_of(2'd1)), 256'(6 - i));
        end
        step(1'b1, 2'd1, 256'(8'h55), 1'b1, 2'd1);
        chk("vc1_emptyrw_unf", 256'(underflow), 256'(1'b1));
        chk("vc1_emptyrw_cnt", 256'(cnt_of(2'd1)), 256'(4'd1));
        chk("vc1_emptyrw_out", out_data, 256'(8'h55));
        chk("vc1_emptyrw_cred", 256'(credit_valid), 256'(1'b0));

        for (int i = 0; i < 4; i++) step(1'b1, 2'd3, 256'(8'hC0 + i), 1'b0, 2'd3);
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            produce    = 1'b0;
            consume    = 1'(pops[k]);
            consume_vc = 2'd3;
            #3;
            chk($sformatf("cred%0d_pre", k), 256'(credit_valid), 256'(prev));
            @(posedge clk);
            #1;
            chk($sformatf("cred%0d_post", k), 256'(credit_valid), 256'(pops[k]));
            if (pops[k] == 1) chk($sformatf("cred%0d_vc", k), 256'(credit_vc), 256'(2'd3));
            prev = pops[k];
        end
        chk("cred_vc3_cnt", 256'(cnt_of(2'd3)), 256'(4'd1));
        step(1'b0, 2'd0, '0, 1'b1, 2'd0);
        chk("cred_empty_valid", 256'(credit_valid), 256'(1'b0));
        chk("cred_empty_vc", 256'(credit_vc), 256'(2'd3));

        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 256'(8'hD0 + i), 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 256'(8'hE0 + i), 1'b0, 2'd3);
        chk("mid_vc0_cnt", 256'(cnt_of(2'd0)), 256'(4'd4));
        chk("mid_vc3_cnt", 256'(cnt_of(2'd3)), 256'(4'd4));
        rst = 1'b1;
        step(1'b1, 2'd3, 256'(8'hEE), 1'b1, 2'd0);
        rst = 1'b0;
        chk_reset("rst2");
        step(1'b1, 2'd3, 256'(8'hAB), 1'b0, 2'd3);
        chk("post_rst_out", out_data, 256'(8'hAB));
        chk("post_rst_cnt", 256'(cnt_of(2'd3)), 256'(4'd1));
        chk("post_rst_empty", 256'(empty), 256'(4'b0111));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
